// File: rtl/stack_burst_reverser_if.sv
// Valid/ready stream bundle carrying one data beat plus an end-of-burst flag.
//   valid : beat present (driven by master)
//   ready : beat accepted when valid & ready (driven by slave)
//   data  : beat payload, DW bits (driven by master)
//   last  : final beat of the burst (driven by master)
interface stack_burst_reverser_if #(
  parameter int unsigned DW = 8
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stack_burst_reverser.sv
// Burst reverser: pushes each incoming burst into an external LIFO stack,
// then pops it back out so the burst is emitted newest-beat-first.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   in_if        : input stream (slave); ready is combinational in FILL
//   out_if       : output stream (master); valid/data/last are registered
//   stk_push_o   : push strobe, same cycle as an input handshake
//   stk_pop_o    : pop strobe, one cycle per output beat
//   stk_d_in_o   : push data (input beat passed straight through)
//   stk_d_out_i  : stack read data, valid one edge after stk_pop_o
//   stk_full_i   : stack holds CAP entries
//   stk_empty_i  : stack holds no entries
//   overflow_o   : sticky, a burst was cut at CAP beats
//   busy_o       : high unless idle in FILL with nothing stacked
module stack_burst_reverser #(
  parameter int unsigned data_bus_width    = 8,
  parameter int unsigned address_bus_width = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  stack_burst_reverser_if.slave         in_if,
  stack_burst_reverser_if.master        out_if,
  output logic                          stk_push_o,
  output logic                          stk_pop_o,
  output logic [data_bus_width-1:0]     stk_d_in_o,
  input  logic [data_bus_width-1:0]     stk_d_out_i,
  input  logic                          stk_full_i,
  input  logic                          stk_empty_i,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int unsigned DW = data_bus_width;
  localparam int unsigned AW = address_bus_width;
  // Largest burst the stack can hold: 2**AW - 1 entries.
  localparam logic [AW-1:0] CAP = '1;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_POP  = 2'd1,
    S_LOAD = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic          in_ready_c;
  logic          push_c;
  logic          pop_c;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    in_ready_c  = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;

    unique case (state_q)
      S_FILL: begin
        // Ready is forced low during reset so no beat slips into the stack.
        in_ready_c = ~rst & ~stk_full_i & (cnt_q < CAP);
        push_c     = in_if.valid & in_ready_c;
        if (push_c) begin
          cnt_d = cnt_q + AW'(1);
          if (in_if.last || (cnt_d == CAP)) begin
            state_d = S_POP;
          end
          // Hitting capacity without a last flag truncates the burst.
          if (!in_if.last && (cnt_d == CAP)) begin
            overflow_d = 1'b1;
          end
        end
      end
      S_POP: begin
        pop_c   = ~stk_empty_i;
        cnt_d   = cnt_q - AW'(1);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // cnt already reflects the pop, so zero means this is the oldest beat.
        out_data_d  = stk_d_out_i;
        out_last_d  = (cnt_q == '0);
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_if.ready) begin
          out_valid_d = 1'b0;
          state_d     = out_last_q ? S_FILL : S_POP;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign in_if.ready  = in_ready_c;
  assign stk_push_o   = push_c;
  assign stk_pop_o    = pop_c;
  assign stk_d_in_o   = in_if.data;
  assign out_if.valid = out_valid_q;
  assign out_if.last  = out_last_q;
  assign out_if.data  = out_data_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = !((state_q == S_FILL) && (cnt_q == '0));

endmodule

// File: doc/stack_burst_reverser.md
# stack_burst_reverser

Master-side controller for the LIFO stack block: accepts a valid/ready input stream, pushes each burst into an attached stack, then pops and emits the burst in reversed order on a valid/ready output stream. It owns the stack's push/pop/d_in and consumes its d_out/full/empty. It sits between a producer and consumer that need last-in-first-out reordering, for example byte-order reversal or undo buffers.

## Interface
- data_bus_width, 8, width of stream data and stack data
- address_bus_width, 4, stack address width; burst capacity CAP = (1<<address_bus_width)-1 = 15 entries
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  data_bus_width  input beat data
- in_last  input  1  final beat of burst
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer ready
- out_data  output  data_bus_width  output beat data
- out_last  output  1  final (oldest) beat of reversed burst
- stk_push  output  1  push strobe to stack
- stk_pop  output  1  pop strobe to stack
- stk_d_in  output  data_bus_width  push data to stack
- stk_d_out  input  data_bus_width  stack read data, updated one edge after stk_pop
- stk_full  input  1  stack holds CAP entries
- stk_empty  input  1  stack holds 0 entries
- overflow  output  1  sticky: a burst was truncated at CAP
- busy  output  1  high in any state other than FILL with cnt==0

## Operation
- Internal count cnt (address_bus_width bits) mirrors stack occupancy; the stack's reset is driven from the same rst source at integration, so both are empty after reset.
- FSM states: FILL, POP, LOAD, OUT.
- FILL: in_ready = ~stk_full & (cnt < CAP). stk_push = in_valid & in_ready, stk_d_in = in_data (combinational). On push: cnt+1. If in_last, or cnt+1 == CAP, go to POP. Truncation (cnt+1 == CAP without in_last) sets overflow.
- POP: stk_pop = 1 for exactly one cycle, cnt-1. Go to LOAD.
- LOAD: out_data <= stk_d_out, out_last <= (cnt == 0), out_valid <= 1. Go to OUT.
- OUT: out_valid held. On out_ready: out_valid <= 0. If out_last, go to FILL, else go to POP.
- stk_push and stk_pop are never high in the same cycle. stk_pop is never issued when cnt == 0. stk_push is never issued when stk_full.
- Beats arriving outside FILL see in_ready = 0 and stay pending. After a truncation, the remaining beats form the next burst.

## Timing
- Reset (rst high at an edge): state FILL, cnt 0, out_valid 0, out_last 0, out_data 0, overflow 0, stk_push/stk_pop 0. in_ready is forced to 0 while rst is high.
- Last beat accepted at edge E0. POP occupies the cycle after E0, LOAD the next. out_valid rises after E2.
- Each subsequent beat takes 3 cycles (POP, LOAD, OUT) when out_ready is held high. FILL accepts 1 beat per cycle.
- out_data and out_last are stable while out_valid & ~out_ready.
- After the out_last handshake, in_ready is high in the next cycle.
- Reset mid-burst discards everything: outputs return to reset values and the stack empties.

## Test plan
- Burst 0x11,0x22,0x33,0x44 with last on 0x44 -> outputs 0x44,0x33,0x22,0x11, out_last only on 0x11; first out_valid 2 cycles after the last accept; overflow stays 0.
- Single beat 0xA5 with last -> one output 0xA5 with out_last=1; exactly one stk_push and one stk_pop.
- 20 beats 0x00..0x13 with no last -> in_ready drops after 15 pushes; outputs 0x0E..0x00, last on 0x00; overflow=1. Then 0x0F..0x13 (last on 0x13) -> 0x13..0x0F.
- Random out_ready backpressure on an 8-beat burst -> order preserved, no duplicates or drops, out_data stable while stalled.
- in_valid held high during drain -> in_ready=0 and stk_push=0 throughout POP/LOAD/OUT.
- rst pulsed for 1 cycle after 2 of 5 outputs -> out_valid=0, overflow=0. Next burst 0x01,0x02 (last) -> 0x02,0x01 with last on 0x01.
